data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
- Responder side of the core's data-memory interface: a word-organised RAM with per-byte write masking.
- Provides a combinational read to the MEM stage, because the core expects read data in the same cycle it drives the address.
- Carries a second, independent read port that drives a dump engine. The engine streams the address range the core has touched (the min/max addresses reported by the core) out as a byte stream over a valid/ready handshake, for the debug UART path.
- Sits beside the core in the computer system, between the core's data-memory port and the debug transmitter.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Must be a power of two. The local constant IDX_W = log2(DEPTH_WORDS).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- addr_i  in  32  core byte address. The word index is addr_i[IDX_W+1:2].
- write_data_i  in  32  lane-aligned store data from the core
- write_en_i  in  1  store strobe
- byte_mask_i  in  4  byte-lane enables; bit k selects bits [8k+7:8k]
- read_data_o  out  32  combinational word at the current word index
- dump_start_i  in  1  one-cycle pulse that requests a dump
- range_min_i  in  32  lowest byte address written (from the core)
- range_max_i  in  32  highest byte address written (from the core)
- dump_data_o  out  8  stream byte
- dump_valid_o  out  1  stream byte valid
- dump_ready_i  in  1  consumer accepts the byte
- dump_busy_o  out  1  dump in progress
- dump_done_o  out  1  one-cycle pulse at the end of a dump

Behaviour:
- Reset: clears the FSM to IDLE. Outputs after reset: dump_valid_o=0, dump_busy_o=0, dump_done_o=0, dump_data_o=0. RAM contents are NOT cleared.
- Core writes:
  - Happen at the posedge when write_en_i=1.
  - Only lanes with byte_mask_i[k]=1 are updated. write_en_i=1 with mask 0000 is a no-op.
  - Address bits above IDX_W+1 are ignored, so addresses alias (wrap) modulo 4*DEPTH_WORDS.
  - Core writes are honoured in every state, including mid-dump and during reset.
- Core reads:
  - read_data_o = RAM[word index] combinationally.
  - Read-during-write to the same word shows the old value until the edge and the new value after it.
- Dump read port: synchronous, one-cycle latency, read-first. If a core write hits the same word in the same cycle, the dump captures the old value.
- Dump FSM:
  - IDLE: on dump_start_i, latch cur = range_min_i>>2 and last = range_max_i>>2, and set busy.
    - If range_min_i > range_max_i (the tracker's empty-range encoding), go to DONE directly.
    - Otherwise go to RD.
  - RD: issue the dump-port read of cur, then go to CAP.
  - CAP: load an 8-byte shift register with {cur<<2 (32-bit byte address), data word}, clear the byte counter, then go to SEND.
  - SEND:
    - dump_valid_o=1 and dump_data_o = current byte, MSB first (address [31:24] first, data [7:0] last).
    - On valid&&ready, advance the byte counter.
    - After the 8th byte is accepted: if cur==last go to DONE, else cur=cur+1 and go to RD.
    - dump_data_o must be held stable while valid && !ready.
  - DONE: pulse dump_done_o for 1 cycle, clear busy, go to IDLE.
- dump_start_i is ignored unless the FSM is in IDLE. A start arriving in the same cycle as the done pulse is ignored.
- Throughput: 8 bytes per word, plus 2 overhead cycles per word (RD and CAP) with dump_ready_i held high.
- Comparisons on cur and last use the full 30-bit word address. RAM indexing uses the low IDX_W bits, so ranges beyond the depth alias.
- Reset mid-dump aborts the dump immediately: no done pulse, valid=0 on the next cycle.

Decomposition:
- Shared package dmem_pkg holds:
  - the dump FSM state typedef (IDLE, RD, CAP, SEND, DONE);
  - the constants DUMP_BYTES_PER_WORD=8 and EMPTY_MIN=32'hFFFF_FFFF.
- One sub-module, byte_masked_ram: array storage, one masked write port, one async read port, one sync read-first port.
- The FSM and shift register live in the top module.

Test Plan:
- Masked write:
  - Write 32'hDEADBEEF to 0x10 with mask 1111, then write 32'h000000AA with mask 0001.
  - Required: read_data_o at 0x10 = 32'hDEADBEAA in the same cycle as the address is driven.
  - A mask 0000 write leaves it unchanged.
- Aliasing: with DEPTH_WORDS=1024, write 32'h12345678 to 0x1000. Required: a read at 0x0 returns 32'h12345678.
- Two-word dump:
  - Store 0x11223344 at 0x20 and 0x55667788 at 0x24. Pulse start with min=0x20, max=0x27, ready held high.
  - Required stream: 00 00 00 20 11 22 33 44 00 00 00 24 55 66 77 88, then one done pulse, busy low.
- Backpressure: same dump with ready toggling every other cycle. Required: identical byte sequence, with dump_data_o stable whenever valid&&!ready.
- Empty range: start with min=0xFFFFFFFF, max=0. Required: no valid byte, done pulse 2 cycles after start.
- Reset mid-dump and collision:
  - Assert rst_i after the 3rd byte. Required: valid=0 next cycle, no done pulse, RAM still holds its values.
  - In a new dump, have the core write the word being read in the RD cycle. Required: the old value is streamed.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared dump FSM state type and constants for the data memory unit
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SEND,
    DONE
  } dump_state_e;

  localparam int          DUMP_BYTES_PER_WORD = 8;
  localparam logic [31:0] EMPTY_MIN           = 32'hFFFF_FFFF;

  // The write tracker reports an untouched memory as min > max.
  function automatic logic is_empty_range(input logic [31:0] lo, input logic [31:0] hi);
    return lo > hi;
  endfunction

endpackage

// File: rtl/byte_masked_ram.sv
// rtl/byte_masked_ram.sv - word RAM with byte-masked write, async read and sync read-first port
module byte_masked_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_mask_i,
  input  logic [31:0]      wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o,
  input  logic             sync_en_i,
  input  logic [IDX_W-1:0] sync_idx_i,
  output logic [31:0]      sync_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] sync_data_q;

  // Sync port samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask_i[k]) begin
          mem_q[wr_idx_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
    if (sync_en_i) begin
      sync_data_q <= mem_q[sync_idx_i];
    end
  end

  assign rd_data_o   = mem_q[rd_idx_i];
  assign sync_data_o = sync_data_q;

endmodule

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - core data RAM with combinational read and a byte-stream dump engine
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        write_en_i,
  input  logic [3:0]  byte_mask_i,
  output logic [31:0] read_data_o,
  input  logic        dump_start_i,
  input  logic [31:0] range_min_i,
  input  logic [31:0] range_max_i,
  output logic [7:0]  dump_data_o,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic        dump_busy_o,
  output logic        dump_done_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dump_state_e state_q;
  logic [29:0] cur_q;
  logic [29:0] last_q;
  logic [63:0] shift_q;
  logic [2:0]  cnt_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] sync_data;
  logic [IDX_W-1:0] word_idx;

  assign word_idx = addr_i[IDX_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  byte_masked_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk_i       (clk_i),
    .wr_idx_i    (word_idx),
    .wr_en_i     (write_en_i),
    .wr_mask_i   (byte_mask_i),
    .wr_data_i   (write_data_i),
    .rd_idx_i    (word_idx),
    .rd_data_o   (read_data_o),
    .sync_en_i   (state_q == RD),
    .sync_idx_i  (cur_q[IDX_W-1:0]),
    .sync_data_o (sync_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished dump and is dropped.
          if (dump_start_i && !done_q) begin
            cur_q   <= range_min_i[31:2];
            last_q  <= range_max_i[31:2];
            busy_q  <= 1'b1;
            state_q <= is_empty_range(range_min_i, range_max_i) ? DONE : RD;
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          shift_q <= {cur_q, 2'b00, sync_data};
          cnt_q   <= '0;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (valid_q && dump_ready_i) begin
            shift_q <= {shift_q[55:0], 8'h00};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'(DUMP_BYTES_PER_WORD - 1)) begin
              valid_q <= 1'b0;
              if (cur_q == last_q) begin
                state_q <= DONE;
              end else begin
                cur_q   <= cur_q + 30'd1;
                state_q <= RD;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dump_data_o  = shift_q[63:56];
  assign dump_valid_o = valid_q;
  assign dump_busy_o  = busy_q;
  assign dump_done_o  = done_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - self-checking bench for data_memory_unit with a byte-stream scoreboard
module tb_data_memory_unit;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] write_data_i = '0;
  logic        write_en_i = 1'b0;
  logic [3:0]  byte_mask_i = '0;
  logic [31:0] read_data_o;
  logic        dump_start_i = 1'b0;
  logic [31:0] range_min_i = '0;
  logic [31:0] range_max_i = '0;
  logic [7:0]  dump_data_o;
  logic        dump_valid_o;
  logic        dump_ready_i = 1'b0;
  logic        dump_busy_o;
  logic        dump_done_o;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model [1024];

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH_WORDS(1024)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .write_en_i   (write_en_i),
    .byte_mask_i  (byte_mask_i),
    .read_data_o  (read_data_o),
    .dump_start_i (dump_start_i),
    .range_min_i  (range_min_i),
    .range_max_i  (range_max_i),
    .dump_data_o  (dump_data_o),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_busy_o  (dump_busy_o),
    .dump_done_o  (dump_done_o)
  );

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) model[a[11:2]][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr_i = a; write_data_i = d; byte_mask_i = m; write_en_i = 1'b1;
    @(negedge clk);
    write_en_i = 1'b0;
    model_write(a, d, m);
  endtask

  task automatic check_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr_i = a;
    #1;
    n_tests++;
    if (read_data_o !== exp) begin
      n_fail++;
      $display("FAIL %s: read_data_o=%h expected %h", name, read_data_o, exp);
    end
  endtask

  task automatic push_expected(input logic [31:0] lo, input logic [31:0] hi);
    logic [29:0] w;
    logic [31:0] a;
    logic [31:0] d;
    w = lo[31:2];
    forever begin
      a = {w, 2'b00};
      d = model[w[9:0]];
      for (int b = 3; b >= 0; b--) exp_q.push_back(a[8*b +: 8]);
      for (int b = 3; b >= 0; b--) exp_q.push_back(d[8*b +: 8]);
      if (w == hi[31:2]) break;
      w = w + 30'd1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] lo, input logic [31:0] hi);
    @(negedge clk);
    range_min_i = lo; range_max_i = hi; dump_start_i = 1'b1;
    @(negedge clk);
    dump_start_i = 1'b0;
  endtask

  // Drains the stream against exp_q; abort_after>0 raises rst_i once that many bytes are accepted.
  task automatic collect_stream(input bit toggle, input int abort_after, input string name);
    int cyc = 0;
    int accepted = 0;
    int dones = 0;
    bit stalled = 0;
    logic [7:0] held = '0;
    logic [7:0] e;
    while (cyc < 400) begin
      @(negedge clk);
      write_en_i = 1'b0;
      dump_ready_i = toggle ? (cyc % 2 == 1) : 1'b1;
      cyc++;
      if (stalled) begin
        n_tests++;
        if (dump_valid_o !== 1'b1 || dump_data_o !== held) begin
          n_fail++;
          $display("FAIL %s_stall_hold: valid=%b data=%h expected valid=1 data=%h", name, dump_valid_o, dump_data_o, held);
        end
      end
      stalled = 0;
      if (dump_done_o === 1'b1) begin
        dones++;
        n_tests++;
        if (dump_busy_o !== 1'b0 || exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL %s_done: busy=%b bytes_left=%0d expected busy=0 bytes_left=0", name, dump_busy_o, exp_q.size());
        end
        break;
      end
      if (dump_valid_o === 1'b1 && dump_ready_i) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra_byte: got %h expected no byte", name, dump_data_o);
        end else begin
          e = exp_q.pop_front();
          if (dump_data_o !== e) begin
            n_fail++;
            $display("FAIL %s_byte%0d: got %h expected %h", name, accepted, dump_data_o, e);
          end
        end
        accepted++;
        if (abort_after == accepted) begin
          rst_i = 1'b1;
          return;
        end
      end else if (dump_valid_o === 1'b1) begin
        held = dump_data_o;
        stalled = 1;
      end
    end
    n_tests++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL %s_timeout: done pulses=%0d expected 1 within 400 cycles", name, dones);
    end
    @(negedge clk);
    n_tests++;
    if (dump_done_o !== 1'b0 || dump_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_done: done=%b busy=%b expected 0 0", name, dump_done_o, dump_busy_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({dump_valid_o, dump_busy_o, dump_done_o, dump_data_o} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%h expected all 0",
               dump_valid_o, dump_busy_o, dump_done_o, dump_data_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_masked_write();
    write_word(32'h10, 32'hDEADBEEF, 4'b1111);
    write_word(32'h10, 32'h000000AA, 4'b0001);
    @(negedge clk);
    check_read(32'h10, 32'hDEADBEAA, "masked_write");
    write_word(32'h10, 32'hFFFFFFFF, 4'b0000);
    check_read(32'h10, 32'hDEADBEAA, "mask_zero_noop");
    @(negedge clk);
    addr_i = 32'h10; write_data_i = 32'h01020304; byte_mask_i = 4'b1111; write_en_i = 1'b1;
    check_read(32'h10, 32'hDEADBEAA, "rdw_old_before_edge");
    @(negedge clk);
    write_en_i = 1'b0;
    model_write(32'h10, 32'h01020304, 4'b1111);
    check_read(32'h10, 32'h01020304, "rdw_new_after_edge");
  endtask

  task automatic test_alias();
    write_word(32'h1000, 32'h12345678, 4'b1111);
    check_read(32'h0, 32'h12345678, "alias_wrap");
  endtask

  task automatic test_two_word_dump();
    write_word(32'h20, 32'h11223344, 4'b1111);
    write_word(32'h24, 32'h55667788, 4'b1111);
    exp_q.delete();
    push_expected(32'h20, 32'h27);
    pulse_start(32'h20, 32'h27);
    collect_stream(1'b0, 0, "dump2");
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    push_expected(32'h20, 32'h27);
    pulse_start(32'h20, 32'h27);
    collect_stream(1'b1, 0, "backpressure");
  endtask

  task automatic test_empty_range();
    pulse_start(EMPTY_MIN, 32'h0);
    n_tests++;
    if (dump_done_o !== 1'b0 || dump_busy_o !== 1'b1 || dump_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_cycle1: done=%b busy=%b valid=%b expected 0 1 0", dump_done_o, dump_busy_o, dump_valid_o);
    end
    @(negedge clk);
    n_tests++;
    if (dump_done_o !== 1'b1 || dump_valid_o !== 1'b0 || dump_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_cycle2: done=%b valid=%b busy=%b expected 1 0 0", dump_done_o, dump_valid_o, dump_busy_o);
    end
    range_min_i = 32'h20; range_max_i = 32'h20; dump_start_i = 1'b1;
    @(negedge clk);
    dump_start_i = 1'b0;
    n_tests++;
    if (dump_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_during_done: busy=%b expected 0", dump_busy_o);
    end
  endtask

  task automatic test_reset_mid_dump();
    exp_q.delete();
    push_expected(32'h20, 32'h27);
    pulse_start(32'h20, 32'h27);
    collect_stream(1'b0, 3, "abort");
    @(negedge clk);
    n_tests++;
    if (dump_valid_o !== 1'b0 || dump_done_o !== 1'b0 || dump_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_cycle: valid=%b done=%b busy=%b expected 0 0 0", dump_valid_o, dump_done_o, dump_busy_o);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (dump_done_o !== 1'b0 || dump_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet%0d: done=%b valid=%b expected 0 0", i, dump_done_o, dump_valid_o);
      end
    end
    exp_q.delete();
    check_read(32'h20, 32'h11223344, "abort_ram_kept0");
    check_read(32'h24, 32'h55667788, "abort_ram_kept1");
  endtask

  task automatic test_collision();
    write_word(32'h30, 32'hCAFEF00D, 4'b1111);
    exp_q.delete();
    push_expected(32'h30, 32'h30);
    pulse_start(32'h30, 32'h30);
    addr_i = 32'h30; write_data_i = 32'h0BADBEEF; byte_mask_i = 4'b1111; write_en_i = 1'b1;
    model_write(32'h30, 32'h0BADBEEF, 4'b1111);
    collect_stream(1'b0, 0, "collision");
    check_read(32'h30, 32'h0BADBEEF, "collision_ram_new");
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_alias();
    test_two_word_dump();
    test_back_to_back();
    test_empty_range();
    test_reset_mid_dump();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
